shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Sequencer for the sync FSM and the 64-bit shift datapath.
- Arms the sync FSM and waits for its ACTIVE state.
- Drives sh_en for exactly N_BITS cycles, then drops it; the falling edge returns the sync FSM to IDLE.
- Enforces a guard interval, counts frames, and flags sync timeouts and stuck sync.

Parameters:
N_BITS, 64, sh_en high-cycle count per frame (≥2)
CNT_W, 7, width of bit_cnt; must satisfy 2^CNT_W > N_BITS
GUARD_CYC, 4, cycles between sh_en fall and re-arm of sync detection (≥1)
TIMEOUT, 1024, WAIT_SYNC cycles before timeout_err; 0 disables timeout
TO_W, 11, timeout counter width; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
en  in  1  sequencer enable, synchronous level
sync_state  in  1  sync FSM state output (1 = ACTIVE)
sh_en  out  1  shift enable to datapath and sync FSM, registered
fsm_rst  out  1  sync FSM re-arm/clear, registered
busy  out  1  high in SHIFT or GUARD
bit_cnt  out  CNT_W  index of the current shift cycle, 0..N_BITS-1
frame_done  out  1  one-cycle pulse at frame end
frame_cnt  out  16  completed frames, wraps 0xFFFF→0
timeout_err  out  1  one-cycle pulse on sync timeout
sync_err  out  1  one-cycle pulse when sync_state is still 1 at end of GUARD

Behaviour:
- One clock. rst asynchronous, active-low. Every flop clears immediately on rst=0.
- Reset values:
  - state=DISABLED, fsm_rst=1, sh_en=0, busy=0, bit_cnt=0.
  - frame_done=0, frame_cnt=0, timeout_err=0, sync_err=0, timeout counter=0.
- All outputs are registered. Decisions are made on inputs sampled at the posedge; outputs update at that edge.
- States: DISABLED, ARM, WAIT_SYNC, SHIFT, GUARD.
- DISABLED:
  - fsm_rst=1, sh_en=0.
  - en=1 → ARM.
- ARM:
  - Lasts exactly 1 cycle, fsm_rst=1.
  - Always → WAIT_SYNC.
- WAIT_SYNC:
  - fsm_rst=0. Timeout counter increments each cycle.
  - sync_state=1 → SHIFT: sh_en=1, bit_cnt=0, timeout counter cleared.
  - TIMEOUT≠0 and counter reaches TIMEOUT-1 with sync_state=0 → timeout_err pulse, → ARM, counter cleared.
  - sync_state=1 in the same cycle as the timeout compare: sync wins, no error.
- SHIFT:
  - sh_en=1, busy=1. bit_cnt increments every cycle.
  - Edge where bit_cnt==N_BITS-1 → GUARD: sh_en=0, bit_cnt=0, frame_done=1 for one cycle, frame_cnt+1.
  - sh_en is therefore high for exactly N_BITS consecutive cycles.
  - sync_state is ignored during SHIFT.
- GUARD:
  - sh_en=0, busy=1, fsm_rst=0. Lasts GUARD_CYC cycles on an internal counter.
  - On the final cycle, sync_state=0 → WAIT_SYNC.
  - On the final cycle, sync_state=1 → sync_err pulse, → ARM (fsm_rst forces the sync FSM clear).
- en=0 in any state → DISABLED at next edge, with sh_en=0 and fsm_rst=1 at that edge.
  - Mid-frame abort: no frame_done, frame_cnt unchanged, bit_cnt=0.
  - en=0 has priority over every other transition, including frame completion on the same edge.
- frame_done, timeout_err and sync_err are mutually exclusive and never high for more than 1 cycle.
- Async reset mid-SHIFT: sh_en drops immediately (asynchronously). No frame_done.

Test Plan:
- Reset then en=1; sync_state rises 3 cycles after en → fsm_rst high 2 cycles (DISABLED, ARM); sh_en high exactly 64 cycles; bit_cnt 0..63; frame_done 1 cycle on sh_en fall edge; frame_cnt=1; busy low after 4 guard cycles.
- en=1, sync_state held 0, TIMEOUT=1024 → timeout_err pulses every 1025 cycles (1024 WAIT + 1 ARM), with fsm_rst=1 during each ARM; sh_en stays 0.
- sync_state left at 1 through GUARD → sync_err pulse on final GUARD cycle, ARM with fsm_rst=1, then next frame starts normally; frame_cnt incremented once only.
- en dropped at bit_cnt=30 → next edge sh_en=0, fsm_rst=1, bit_cnt=0, no frame_done, frame_cnt unchanged; re-enable → full 64-cycle frame.
- Async rst asserted mid-SHIFT, between clock edges → sh_en=0 and all counters 0 immediately; after release with en=1, sequence restarts from ARM.
- Preload frame_cnt near wrap (run 65536 frames, or force 0xFFFF) → next frame_done gives frame_cnt=0x0000; also timeout compare coinciding with sync_state=1 → SHIFT entered, no timeout_err.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: frame sequencer for the sync FSM and the shift datapath.
// Arms sync detection, waits for ACTIVE, then runs one N_BITS-cycle frame.
//
// Ports:
//   clk, rst (async, active-low)    - clock and reset
//   en                              - sequencer enable (level)
//   sync_state                      - sync FSM state, 1 = ACTIVE
//   sh_en, fsm_rst                  - shift enable / sync FSM clear
//   busy, bit_cnt                   - frame in progress / shift index
//   frame_done, frame_cnt           - end-of-frame pulse / frame counter
//   timeout_err, sync_err           - sync timeout / stuck-sync pulses
module shift_seq_ctrl #(
    parameter int N_BITS    = 64,
    parameter int CNT_W     = 7,
    parameter int GUARD_CYC = 4,
    parameter int TIMEOUT   = 1024,
    parameter int TO_W      = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_state,
    output logic             sh_en,
    output logic             fsm_rst,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             timeout_err,
    output logic             sync_err
);

    localparam int GW = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(N_BITS - 1);
    localparam logic [GW-1:0]    GRD_LAST = GW'(GUARD_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_DIS,
        S_ARM,
        S_WAIT,
        S_SHIFT,
        S_GUARD
    } state_t;

    state_t           state_q;
    logic             sh_en_q;
    logic             fsm_rst_q;
    logic             busy_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             frame_done_q;
    logic [15:0]      frame_cnt_q;
    logic             timeout_err_q;
    logic             sync_err_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic [GW-1:0]    g_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_DIS;
            sh_en_q       <= 1'b0;
            fsm_rst_q     <= 1'b1;
            busy_q        <= 1'b0;
            bit_cnt_q     <= '0;
            frame_done_q  <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_err_q <= 1'b0;
            sync_err_q    <= 1'b0;
            to_cnt_q      <= '0;
            g_cnt_q       <= '0;
        end else begin
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            sync_err_q    <= 1'b0;
            // Disable overrides everything, including a frame ending now.
            if (!en) begin
                state_q   <= S_DIS;
                sh_en_q   <= 1'b0;
                fsm_rst_q <= 1'b1;
                busy_q    <= 1'b0;
                bit_cnt_q <= '0;
                to_cnt_q  <= '0;
                g_cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    S_DIS: begin
                        state_q   <= S_ARM;
                        fsm_rst_q <= 1'b1;
                    end
                    S_ARM: begin
                        state_q   <= S_WAIT;
                        fsm_rst_q <= 1'b0;
                        to_cnt_q  <= '0;
                    end
                    S_WAIT: begin
                        // Sync is checked first so it beats a same-cycle timeout.
                        if (sync_state) begin
                            state_q   <= S_SHIFT;
                            sh_en_q   <= 1'b1;
                            busy_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            to_cnt_q  <= '0;
                        end else if (TIMEOUT != 0 && to_cnt_q == TO_LAST) begin
                            state_q       <= S_ARM;
                            fsm_rst_q     <= 1'b1;
                            timeout_err_q <= 1'b1;
                            to_cnt_q      <= '0;
                        end else begin
                            to_cnt_q <= to_cnt_q + 1'b1;
                        end
                    end
                    S_SHIFT: begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_q      <= S_GUARD;
                            sh_en_q      <= 1'b0;
                            bit_cnt_q    <= '0;
                            g_cnt_q      <= '0;
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 16'd1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                    S_GUARD: begin
                        if (g_cnt_q == GRD_LAST) begin
                            busy_q  <= 1'b0;
                            g_cnt_q <= '0;
                            // Sync still ACTIVE here means the sync FSM is stuck.
                            if (sync_state) begin
                                state_q    <= S_ARM;
                                fsm_rst_q  <= 1'b1;
                                sync_err_q <= 1'b1;
                            end else begin
                                state_q <= S_WAIT;
                            end
                        end else begin
                            g_cnt_q <= g_cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= S_DIS;
                        sh_en_q   <= 1'b0;
                        fsm_rst_q <= 1'b1;
                        busy_q    <= 1'b0;
                        bit_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign sh_en       = sh_en_q;
    assign fsm_rst     = fsm_rst_q;
    assign busy        = busy_q;
    assign bit_cnt     = bit_cnt_q;
    assign frame_done  = frame_done_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = timeout_err_q;
    assign sync_err    = sync_err_q;

endmodule
